// File: rtl/wb_arbiter_queued.sv
// wb_arbiter_queued: writeback stage that buffers results from several
// functional units in small per-unit FIFOs and arbitrates them, one per
// cycle, onto the single register-file write port.
module wb_arbiter_queued #(
    parameter int NUM_UNITS = 3,
    parameter int DATA_W    = 32,
    parameter int ADDR_W    = 5,
    parameter int DEPTH     = 2,
    parameter int RR_MODE   = 1
) (
    input  logic                           clock,
    input  logic                           reset,
    input  logic [NUM_UNITS-1:0]           unit_valid,
    output logic [NUM_UNITS-1:0]           unit_ready,
    input  logic [NUM_UNITS-1:0]           unit_writereg,
    input  logic [NUM_UNITS*ADDR_W-1:0]    unit_regdest,
    input  logic [NUM_UNITS*DATA_W-1:0]    unit_wbvalue,
    output logic                           wb_reg_en,
    output logic [ADDR_W-1:0]              wb_reg_addr,
    output logic [DATA_W-1:0]              wb_reg_data,
    output logic [$clog2(NUM_UNITS)-1:0]   wb_grant_id,
    output logic [NUM_UNITS-1:0]           wb_pending,
    output logic                           wb_idle
);

    localparam int ID_W  = $clog2(NUM_UNITS);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic [ADDR_W-1:0] mem_addr [NUM_UNITS][DEPTH];
    logic [DATA_W-1:0] mem_data [NUM_UNITS][DEPTH];
    logic [PTR_W-1:0]  rd_ptr   [NUM_UNITS];
    logic [PTR_W-1:0]  wr_ptr   [NUM_UNITS];
    logic [CNT_W-1:0]  count    [NUM_UNITS];

    logic [NUM_UNITS-1:0] full;
    logic [NUM_UNITS-1:0] nonempty;
    logic [NUM_UNITS-1:0] push;
    logic [NUM_UNITS-1:0] pop;
    logic [ID_W-1:0]      rr_ptr;
    logic [ID_W-1:0]      grant_idx;
    logic                 grant_any;
    logic [ADDR_W-1:0]    head_addr;
    logic [DATA_W-1:0]    head_data;

    // Channel status and handshake; ready comes only from stored occupancy
    // and reset, and filtered results are accepted but never stored.
    always_comb begin
        full       = '0;
        nonempty   = '0;
        unit_ready = '0;
        push       = '0;
        for (int i = 0; i < NUM_UNITS; i++) begin
            full[i]       = (count[i] == CNT_W'(DEPTH));
            nonempty[i]   = (count[i] != '0);
            unit_ready[i] = reset && !full[i];
            push[i]       = unit_valid[i] && unit_ready[i] && unit_writereg[i]
                            && (unit_regdest[i*ADDR_W +: ADDR_W] != '0);
        end
    end

    // Pick one non-empty channel: rotating search after the last winner,
    // or lowest index first when round-robin is disabled.
    always_comb begin
        int              cand;
        logic [ID_W-1:0] cand_idx;
        grant_any = 1'b0;
        grant_idx = '0;
        cand      = 0;
        cand_idx  = '0;
        if (RR_MODE != 0) begin
            for (int k = 1; k <= NUM_UNITS; k++) begin
                cand = int'(rr_ptr) + k;
                if (cand >= NUM_UNITS) begin
                    cand = cand - NUM_UNITS;
                end
                cand_idx = ID_W'(cand);
                if (!grant_any && nonempty[cand_idx]) begin
                    grant_any = 1'b1;
                    grant_idx = cand_idx;
                end
            end
        end else begin
            for (int i = 0; i < NUM_UNITS; i++) begin
                if (!grant_any && nonempty[i]) begin
                    grant_any = 1'b1;
                    grant_idx = ID_W'(i);
                end
            end
        end
    end

    // Pop strobe and head entry of the granted channel.
    always_comb begin
        pop       = '0;
        head_addr = mem_addr[grant_idx][rd_ptr[grant_idx]];
        head_data = mem_data[grant_idx][rd_ptr[grant_idx]];
        if (grant_any) begin
            pop[grant_idx] = 1'b1;
        end
    end

    // FIFO storage writes; contents need no reset because occupancy gates reads.
    always_ff @(posedge clock) begin
        for (int i = 0; i < NUM_UNITS; i++) begin
            if (push[i]) begin
                mem_addr[i][wr_ptr[i]] <= unit_regdest[i*ADDR_W +: ADDR_W];
                mem_data[i][wr_ptr[i]] <= unit_wbvalue[i*DATA_W +: DATA_W];
            end
        end
    end

    // FIFO pointers, occupancy, arbitration pointer and the registered write port.
    always_ff @(posedge clock) begin
        if (!reset) begin
            for (int i = 0; i < NUM_UNITS; i++) begin
                rd_ptr[i] <= '0;
                wr_ptr[i] <= '0;
                count[i]  <= '0;
            end
            rr_ptr      <= ID_W'(NUM_UNITS - 1);
            wb_reg_en   <= 1'b0;
            wb_reg_addr <= '0;
            wb_reg_data <= '0;
            wb_grant_id <= '0;
        end else begin
            for (int i = 0; i < NUM_UNITS; i++) begin
                if (push[i]) begin
                    wr_ptr[i] <= wr_ptr[i] + PTR_W'(1);
                end
                if (pop[i]) begin
                    rd_ptr[i] <= rd_ptr[i] + PTR_W'(1);
                end
                count[i] <= count[i] + {{(CNT_W-1){1'b0}}, push[i]}
                                     - {{(CNT_W-1){1'b0}}, pop[i]};
            end
            if (grant_any) begin
                wb_reg_en   <= 1'b1;
                wb_reg_addr <= head_addr;
                wb_reg_data <= head_data;
                wb_grant_id <= grant_idx;
                if (RR_MODE != 0) begin
                    rr_ptr <= grant_idx;
                end
            end else begin
                wb_reg_en <= 1'b0;
            end
        end
    end

    assign wb_pending = nonempty;
    assign wb_idle    = ~|nonempty && !wb_reg_en;

endmodule

// File: tb/tb_wb_arbiter_queued.sv
// tb_wb_arbiter_queued: directed and randomized stimulus for the queued
// writeback arbiter, checked against a queue-based reference model and a
// scoreboard of expected register-file writes.
module tb_wb_arbiter_queued;

    localparam int NU  = 3;
    localparam int AW  = 5;
    localparam int DW  = 32;
    localparam int DEP = 2;
    localparam int RR  = 1;
    localparam int IW  = $clog2(NU);

    logic              clock = 1'b0;
    logic              reset = 1'b0;
    logic [NU-1:0]     unit_valid = '0;
    logic [NU-1:0]     unit_ready;
    logic [NU-1:0]     unit_writereg = '0;
    logic [NU*AW-1:0]  unit_regdest = '0;
    logic [NU*DW-1:0]  unit_wbvalue = '0;
    logic              wb_reg_en;
    logic [AW-1:0]     wb_reg_addr;
    logic [DW-1:0]     wb_reg_data;
    logic [IW-1:0]     wb_grant_id;
    logic [NU-1:0]     wb_pending;
    logic              wb_idle;

    wb_arbiter_queued #(
        .NUM_UNITS(NU), .DATA_W(DW), .ADDR_W(AW), .DEPTH(DEP), .RR_MODE(RR)
    ) dut (
        .clock(clock),
        .reset(reset),
        .unit_valid(unit_valid),
        .unit_ready(unit_ready),
        .unit_writereg(unit_writereg),
        .unit_regdest(unit_regdest),
        .unit_wbvalue(unit_wbvalue),
        .wb_reg_en(wb_reg_en),
        .wb_reg_addr(wb_reg_addr),
        .wb_reg_data(wb_reg_data),
        .wb_grant_id(wb_grant_id),
        .wb_pending(wb_pending),
        .wb_idle(wb_idle)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } ent_t;

    typedef struct {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
        int            id;
    } exp_t;

    ent_t          mq [NU][$];
    exp_t          sb [$];
    int            rr_m = NU - 1;
    logic          m_en = 1'b0;
    logic [AW-1:0] m_addr = '0;
    logic [DW-1:0] m_data = '0;

    int n_checks = 0;
    int n_fail   = 0;

    logic [NU-1:0]    n_valid = '0;
    logic [NU-1:0]    n_writereg = '0;
    logic [NU*AW-1:0] n_regdest = '0;
    logic [NU*DW-1:0] n_wbvalue = '0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: per-unit queues, one write per cycle chosen from the
    // arbitration rules, with acceptance decided from occupancy before the pop.
    task automatic model_step();
        int   grant;
        int   idx;
        bit   rdy [NU];
        ent_t e;
        if (!reset) begin
            for (int i = 0; i < NU; i++) mq[i].delete();
            rr_m   = NU - 1;
            m_en   = 1'b0;
            m_addr = '0;
            m_data = '0;
            return;
        end
        for (int i = 0; i < NU; i++) rdy[i] = (mq[i].size() < DEP);
        grant = -1;
        if (RR != 0) begin
            for (int k = 1; k <= NU; k++) begin
                idx = (rr_m + k) % NU;
                if (grant < 0 && mq[idx].size() != 0) grant = idx;
            end
        end else begin
            for (int i = 0; i < NU; i++) begin
                if (grant < 0 && mq[i].size() != 0) grant = i;
            end
        end
        if (grant >= 0) begin
            e      = mq[grant].pop_front();
            m_en   = 1'b1;
            m_addr = e.addr;
            m_data = e.data;
            if (RR != 0) rr_m = grant;
            sb.push_back('{addr: e.addr, data: e.data, id: grant});
        end else begin
            m_en = 1'b0;
        end
        for (int i = 0; i < NU; i++) begin
            if (unit_valid[i] && rdy[i] && unit_writereg[i]
                && unit_regdest[i*AW +: AW] != '0) begin
                mq[i].push_back('{addr: unit_regdest[i*AW +: AW],
                                  data: unit_wbvalue[i*DW +: DW]});
            end
        end
    endtask

    // Advance the reference model on every active clock edge.
    always @(posedge clock) model_step();

    // Scoreboard monitor: every write the DUT presents must match the next expected write.
    initial begin
        exp_t e;
        forever begin
            @(posedge clock);
            #1;
            if (wb_reg_en) begin
                if (sb.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("[TB] FAIL sb_unexpected: write addr=%0d data=0x%0h grant=%0d with nothing expected",
                             wb_reg_addr, wb_reg_data, wb_grant_id);
                end else begin
                    e = sb.pop_front();
                    check("sb_addr", 64'(wb_reg_addr), 64'(e.addr));
                    check("sb_data", 64'(wb_reg_data), 64'(e.data));
                    check("sb_grant", 64'(wb_grant_id), 64'(e.id));
                end
            end
        end
    end

    task automatic check_output();
        logic [NU-1:0] er;
        logic [NU-1:0] ep;
        for (int i = 0; i < NU; i++) begin
            er[i] = reset && (mq[i].size() < DEP);
            ep[i] = (mq[i].size() != 0);
        end
        check("unit_ready", 64'(unit_ready), 64'(er));
        check("wb_pending", 64'(wb_pending), 64'(ep));
        check("wb_idle", 64'(wb_idle), 64'((ep == '0) && !m_en));
        check("wb_reg_en", 64'(wb_reg_en), 64'(m_en));
        check("wb_reg_addr", 64'(wb_reg_addr), 64'(m_addr));
        check("wb_reg_data", 64'(wb_reg_data), 64'(m_data));
    endtask

    task automatic set_unit(input int i, input logic wr, input logic [AW-1:0] dest,
                            input logic [DW-1:0] data);
        n_valid[i]            = 1'b1;
        n_writereg[i]         = wr;
        n_regdest[i*AW +: AW] = dest;
        n_wbvalue[i*DW +: DW] = data;
    endtask

    task automatic apply_stimulus(input logic rst);
        @(negedge clock);
        reset         = rst;
        unit_valid    = n_valid;
        unit_writereg = n_writereg;
        unit_regdest  = n_regdest;
        unit_wbvalue  = n_wbvalue;
        n_valid       = '0;
        n_writereg    = '0;
        n_regdest     = '0;
        n_wbvalue     = '0;
        #1;
        check_output();
    endtask

    task automatic idle(input int n);
        for (int c = 0; c < n; c++) apply_stimulus(1'b1);
    endtask

    initial begin
        $display("[TB] reset with all units offering");
        for (int c = 0; c < 2; c++) begin
            for (int i = 0; i < NU; i++) set_unit(i, 1'b1, AW'(i + 1), DW'(32'h100 + i));
            apply_stimulus(1'b0);
        end
        idle(2);

        $display("[TB] single result");
        set_unit(1, 1'b1, 5'd5, 32'hDEADBEEF);
        apply_stimulus(1'b1);
        idle(3);

        $display("[TB] three-way collision, twice");
        for (int r = 0; r < 2; r++) begin
            for (int i = 0; i < NU; i++) set_unit(i, 1'b1, AW'(i + 1), DW'(32'hA0 + 16 * r + i));
            apply_stimulus(1'b1);
            idle(4);
        end

        $display("[TB] backpressure on unit 2");
        for (int c = 0; c < 6; c++) begin
            set_unit(0, 1'b1, AW'(10 + c), DW'(32'h1000 + c));
            set_unit(1, 1'b1, AW'(16 + c), DW'(32'h1100 + c));
            set_unit(2, 1'b1, 5'd20, DW'(32'h2000 + c));
            apply_stimulus(1'b1);
        end
        idle(10);

        $display("[TB] filtered results");
        set_unit(0, 1'b0, 5'd7, 32'h77);
        apply_stimulus(1'b1);
        set_unit(1, 1'b1, 5'd0, 32'h88);
        apply_stimulus(1'b1);
        idle(2);

        $display("[TB] mid-operation reset");
        for (int c = 0; c < 3; c++) begin
            for (int i = 0; i < NU; i++) set_unit(i, 1'b1, AW'(3 + i), DW'(32'h300 + 8 * c + i));
            apply_stimulus(1'b1);
        end
        apply_stimulus(1'b0);
        set_unit(0, 1'b1, 5'd9, 32'h9000);
        set_unit(2, 1'b1, 5'd11, 32'h9002);
        apply_stimulus(1'b1);
        idle(4);

        $display("[TB] randomized traffic");
        for (int c = 0; c < 1500; c++) begin
            for (int i = 0; i < NU; i++) begin
                if ($urandom_range(0, 3) != 0) begin
                    set_unit(i, $urandom_range(0, 7) != 0, AW'($urandom_range(0, 31)), DW'($urandom));
                end
            end
            apply_stimulus($urandom_range(0, 63) != 0);
        end
        idle(12);

        check("sb_drain", 64'(sb.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
